// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and memory (slave).
interface fetch_stage_if #(
  parameter int WIDTH = 32
);
  logic             IReqF;
  logic [WIDTH-1:0] IAddrF;
  logic [WIDTH-1:0] IRdataF;
  logic             IReadyF;

  modport master (
    output IReqF,
    output IAddrF,
    input  IRdataF,
    input  IReadyF
  );

  modport slave (
    input  IReqF,
    input  IAddrF,
    output IRdataF,
    output IReadyF
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ready-based memory fetch, one-entry
// stall buffer and the IF/ID pipeline register.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              BranchTakenE,
  input  logic [WIDTH-1:0]  ALUResultE,
  input  logic              PCSrcW,
  input  logic [WIDTH-1:0]  ResultW,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  output logic              PCWrPendingF,
  output logic              IMissStallF,
  output logic [WIDTH-1:0]  InstrD,
  output logic [WIDTH-1:0]  PCPlus8D,
  output logic              ValidD,
  fetch_stage_if.master     imem
);

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] instr_buf;
  logic [WIDTH-1:0] fetched;
  logic             redirect;
  logic             have_instr;
  logic             deliver;
  logic             capture;

  assign redirect   = BranchTakenE | PCSrcW;
  assign have_instr = (state == HELD) | ((state == FETCH) & imem.IReadyF);
  assign deliver    = have_instr & ~StallF & ~redirect;
  assign fetched    = (state == HELD) ? instr_buf : imem.IRdataF;

  // A redirect always wins, even over a stalled front end or a pending delivery.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    if (redirect) begin
      pc_next    = BranchTakenE ? ALUResultE : ResultW;
      state_next = FETCH;
    end else if (deliver) begin
      pc_next    = pc + WIDTH'(4);
      state_next = FETCH;
    end else if ((state == FETCH) && imem.IReadyF && StallF) begin
      state_next = HELD;
      capture    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instr_buf <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (redirect) begin
        instr_buf <= '0;
      end else if (capture) begin
        instr_buf <= imem.IRdataF;
      end
    end
  end

  // IF/ID register: flush beats stall; a cycle with nothing delivered is a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= '0;
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= '0;
      PCPlus8D <= '0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus8D <= PCPlus8D;
      ValidD   <= ValidD;
    end else if (deliver) begin
      InstrD   <= fetched;
      PCPlus8D <= pc + WIDTH'(8);
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= '0;
      PCPlus8D <= PCPlus8D;
      ValidD   <= 1'b0;
    end
  end

  assign imem.IReqF   = (state == FETCH);
  assign imem.IAddrF  = pc;
  assign IMissStallF  = (state == FETCH) & ~imem.IReadyF;
  assign PCWrPendingF = PCSrcD | PCSrcE | PCSrcM;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage; memory returns 0xA0 + address.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        valid;
    logic        check_pc8;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD;
  logic        BranchTakenE, PCSrcW;
  logic [31:0] ALUResultE, ResultW;
  logic        PCSrcD, PCSrcE, PCSrcM;
  logic        PCWrPendingF, IMissStallF, ValidD;
  logic [31:0] InstrD, PCPlus8D;
  logic        ready;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  fetch_stage_if #(.WIDTH(32)) imem ();

  assign imem.IReadyF = ready;
  assign imem.IRdataF = imem.IAddrF + 32'h0000_00A0;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .BranchTakenE (BranchTakenE),
    .ALUResultE   (ALUResultE),
    .PCSrcW       (PCSrcW),
    .ResultW      (ResultW),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCWrPendingF (PCWrPendingF),
    .IMissStallF  (IMissStallF),
    .InstrD       (InstrD),
    .PCPlus8D     (PCPlus8D),
    .ValidD       (ValidD),
    .imem         (imem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_controls();
    StallF = 0; StallD = 0; FlushD = 0;
    BranchTakenE = 0; ALUResultE = '0;
    PCSrcW = 0; ResultW = '0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc8,
                      input logic valid, input logic check_pc8);
    exp_t e;
    e.instr = instr; e.pc8 = pc8; e.valid = valid; e.check_pc8 = check_pc8;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 0; ready = 0;
    clear_controls();
    #2;
    checks++; if (imem.IReqF !== 1'b1) begin errors++; $display("[TB] FAIL reset_ireq got %b want 1", imem.IReqF); end
    checks++; if (imem.IAddrF !== 32'h0) begin errors++; $display("[TB] FAIL reset_iaddr got %h want 0", imem.IAddrF); end
    checks++; if (ValidD !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", ValidD); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h want 0", InstrD); end
    checks++; if (PCPlus8D !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc8 got %h want 0", PCPlus8D); end
    checks++; if (IMissStallF !== 1'b1) begin errors++; $display("[TB] FAIL reset_miss got %b want 1", IMissStallF); end
    tick();
    checks++; if (imem.IAddrF !== 32'h0) begin errors++; $display("[TB] FAIL reset_hold_iaddr got %h want 0", imem.IAddrF); end
  endtask

  task automatic test_streaming();
    exp_t e;
    reset = 1; ready = 1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      checks++; if (imem.IAddrF !== a) begin errors++; $display("[TB] FAIL stream_iaddr[%0d] got %h want %h", i, imem.IAddrF, a); end
      push(a + 32'hA0, a + 32'd8, 1'b1, 1'b1);
      tick();
      e = sb.pop_front();
      checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL stream_instr[%0d] got %h want %h", i, InstrD, e.instr); end
      checks++; if (PCPlus8D !== e.pc8) begin errors++; $display("[TB] FAIL stream_pc8[%0d] got %h want %h", i, PCPlus8D, e.pc8); end
      checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL stream_valid[%0d] got %b want %b", i, ValidD, e.valid); end
    end
  endtask

  task automatic test_miss();
    exp_t e;
    ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (IMissStallF !== 1'b1) begin errors++; $display("[TB] FAIL miss_stall[%0d] got %b want 1", i, IMissStallF); end
      checks++; if (imem.IAddrF !== 32'h10) begin errors++; $display("[TB] FAIL miss_iaddr[%0d] got %h want 10", i, imem.IAddrF); end
      push(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      e = sb.pop_front();
      checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL miss_valid[%0d] got %b want %b", i, ValidD, e.valid); end
      checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL miss_instr[%0d] got %h want %h", i, InstrD, e.instr); end
    end
    ready = 1;
    #1;
    checks++; if (IMissStallF !== 1'b0) begin errors++; $display("[TB] FAIL miss_clear got %b want 0", IMissStallF); end
    push(32'hB0, 32'h18, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL miss_resume_instr got %h want %h", InstrD, e.instr); end
    checks++; if (PCPlus8D !== e.pc8) begin errors++; $display("[TB] FAIL miss_resume_pc8 got %h want %h", PCPlus8D, e.pc8); end
    checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL miss_resume_valid got %b want %b", ValidD, e.valid); end
  endtask

  task automatic test_hold();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h14 + 32'(4 * i);
      push(a + 32'hA0, a + 32'd8, 1'b1, 1'b1);
      tick();
      e = sb.pop_front();
      checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL hold_pre_instr[%0d] got %h want %h", i, InstrD, e.instr); end
    end
    StallF = 1; StallD = 1;
    for (int i = 0; i < 2; i++) begin
      push(32'hBC, 32'h24, 1'b1, 1'b1);
      tick();
      e = sb.pop_front();
      checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL hold_instr[%0d] got %h want %h", i, InstrD, e.instr); end
      checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL hold_valid[%0d] got %b want %b", i, ValidD, e.valid); end
      checks++; if (imem.IReqF !== 1'b0) begin errors++; $display("[TB] FAIL hold_ireq[%0d] got %b want 0", i, imem.IReqF); end
      checks++; if (imem.IAddrF !== 32'h20) begin errors++; $display("[TB] FAIL hold_iaddr[%0d] got %h want 20", i, imem.IAddrF); end
    end
    StallF = 0; StallD = 0; ready = 0;
    push(32'hC0, 32'h28, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL release_instr got %h want %h", InstrD, e.instr); end
    checks++; if (PCPlus8D !== e.pc8) begin errors++; $display("[TB] FAIL release_pc8 got %h want %h", PCPlus8D, e.pc8); end
    checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL release_valid got %b want %b", ValidD, e.valid); end
    checks++; if (imem.IAddrF !== 32'h24) begin errors++; $display("[TB] FAIL release_iaddr got %h want 24", imem.IAddrF); end
    checks++; if (imem.IReqF !== 1'b1) begin errors++; $display("[TB] FAIL release_ireq got %b want 1", imem.IReqF); end
  endtask

  task automatic test_redirect_held();
    exp_t e;
    ready = 1; StallF = 1; StallD = 1;
    tick();
    checks++; if (imem.IReqF !== 1'b0) begin errors++; $display("[TB] FAIL redir_held_ireq got %b want 0", imem.IReqF); end
    BranchTakenE = 1; ALUResultE = 32'h100; FlushD = 1;
    push(32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    checks++; if (imem.IAddrF !== 32'h100) begin errors++; $display("[TB] FAIL redir_iaddr got %h want 100", imem.IAddrF); end
    checks++; if (imem.IReqF !== 1'b1) begin errors++; $display("[TB] FAIL redir_ireq got %b want 1", imem.IReqF); end
    checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL redir_valid got %b want %b", ValidD, e.valid); end
    checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL redir_instr got %h want %h", InstrD, e.instr); end
    checks++; if (PCPlus8D !== e.pc8) begin errors++; $display("[TB] FAIL redir_pc8 got %h want %h", PCPlus8D, e.pc8); end
    clear_controls();
    ready = 0;
    #1;
    checks++; if (IMissStallF !== 1'b1) begin errors++; $display("[TB] FAIL redir_miss got %b want 1", IMissStallF); end
    push(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL redir_bubble_valid got %b want %b", ValidD, e.valid); end
    ready = 1;
    push(32'h1A0, 32'h108, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL redir_target_instr got %h want %h", InstrD, e.instr); end
    checks++; if (PCPlus8D !== e.pc8) begin errors++; $display("[TB] FAIL redir_target_pc8 got %h want %h", PCPlus8D, e.pc8); end
    checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL redir_target_valid got %b want %b", ValidD, e.valid); end
  endtask

  task automatic test_priority();
    exp_t e;
    PCSrcW = 1; ResultW = 32'h200; BranchTakenE = 1; ALUResultE = 32'h300; ready = 1;
    push(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (imem.IAddrF !== 32'h300) begin errors++; $display("[TB] FAIL prio_iaddr got %h want 300", imem.IAddrF); end
    checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL prio_valid got %b want %b", ValidD, e.valid); end
    checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL prio_instr got %h want %h", InstrD, e.instr); end
    clear_controls();
    PCSrcW = 1; ResultW = 32'h200;
    tick();
    checks++; if (imem.IAddrF !== 32'h200) begin errors++; $display("[TB] FAIL wb_redir_iaddr got %h want 200", imem.IAddrF); end
    clear_controls();
    for (int i = 0; i < 4; i++) begin
      logic want;
      PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2);
      want = (i != 3);
      #1;
      checks++; if (PCWrPendingF !== want) begin errors++; $display("[TB] FAIL pending[%0d] got %b want %b", i, PCWrPendingF, want); end
    end
    clear_controls();
  endtask

  task automatic test_async_reset();
    exp_t e;
    ready = 1;
    push(32'h2A0, 32'h208, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL pre_reset_instr got %h want %h", InstrD, e.instr); end
    StallF = 1; StallD = 1;
    tick();
    checks++; if (imem.IReqF !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_held got %b want 0", imem.IReqF); end
    #3;
    reset = 0;
    #1;
    checks++; if (ValidD !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid got %b want 0", ValidD); end
    checks++; if (InstrD !== 32'h0) begin errors++; $display("[TB] FAIL areset_instr got %h want 0", InstrD); end
    checks++; if (PCPlus8D !== 32'h0) begin errors++; $display("[TB] FAIL areset_pc8 got %h want 0", PCPlus8D); end
    checks++; if (imem.IAddrF !== 32'h0) begin errors++; $display("[TB] FAIL areset_iaddr got %h want 0", imem.IAddrF); end
    checks++; if (imem.IReqF !== 1'b1) begin errors++; $display("[TB] FAIL areset_ireq got %b want 1", imem.IReqF); end
    sb.delete();
    #2;
    clear_controls();
    reset = 1;
  endtask

  task automatic test_wrap();
    exp_t e;
    ready = 0;
    BranchTakenE = 1; ALUResultE = 32'hFFFF_FFFC;
    push(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL wrap_bubble_valid got %b want %b", ValidD, e.valid); end
    clear_controls();
    ready = 1;
    checks++; if (imem.IAddrF !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_iaddr got %h want fffffffc", imem.IAddrF); end
    push(32'h0000_009C, 32'h4, 1'b1, 1'b1);
    push(32'h0000_00A0, 32'h8, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++; if (InstrD !== e.instr) begin errors++; $display("[TB] FAIL wrap_instr[%0d] got %h want %h", i, InstrD, e.instr); end
      checks++; if (PCPlus8D !== e.pc8) begin errors++; $display("[TB] FAIL wrap_pc8[%0d] got %h want %h", i, PCPlus8D, e.pc8); end
      checks++; if (ValidD !== e.valid) begin errors++; $display("[TB] FAIL wrap_valid[%0d] got %b want %b", i, ValidD, e.valid); end
      if (i == 0) begin
        checks++; if (imem.IAddrF !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next_iaddr got %h want 0", imem.IAddrF); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_miss();
    test_hold();
    test_redirect_held();
    test_priority();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core, directly upstream of the hazard unit and decode. It holds the program counter, talks to instruction memory over a ready-based handshake, and buffers a fetched instruction when the front end is stalled. It honours StallF/StallD/FlushD and the branch/writeback redirects, and loads the IF/ID pipeline register. It also produces PCWrPendingF and an instruction-miss stall request, both of which feed the hazard unit.

## Interface
- WIDTH, 32, address/data width
- RESET_PC, 0, PC value after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- StallF, StallD, FlushD  in  1 each  hazard-unit controls
- BranchTakenE  in  1  branch resolved taken in Execute; target on ALUResultE
- ALUResultE  in  WIDTH  branch target
- PCSrcW  in  1  PC written in Writeback; target on ResultW
- ResultW  in  WIDTH  writeback PC target
- PCSrcD, PCSrcE, PCSrcM  in  1 each  PC-write instruction in D/E/M
- PCWrPendingF  out  1  PCSrcD | PCSrcE | PCSrcM (combinational)
- IReqF  out  1  fetch request
- IAddrF  out  WIDTH  fetch address (= PCF)
- IRdataF  in  WIDTH  instruction data, valid when IReadyF=1
- IReadyF  in  1  memory returns data for the current IAddrF this cycle
- IMissStallF  out  1  fetch miss; ORed into StallF externally
- InstrD  out  WIDTH  IF/ID instruction
- PCPlus8D  out  WIDTH  IF/ID fetch PC + 8
- ValidD  out  1  InstrD holds a real instruction

## Operation
- State machine with two states.
  - FETCH: IReqF=1, IAddrF=PCF.
  - HELD: IReqF=0. The instruction is in the internal buffer InstrBuf with its PC.
- Delivery this cycle is true when (FETCH & IReadyF) or HELD, and also StallF=0 and there is no redirect.
- Redirect: BranchTakenE=1 or PCSrcW=1.
  - Next PC = ALUResultE if BranchTakenE, else ResultW. BranchTakenE has priority.
  - The redirect loads PCF even when StallF=1.
  - Next state is FETCH; any buffered instruction is discarded.
- With no redirect:
  - On delivery, PCF <= PCF+4.
  - In FETCH with IReadyF=1 and StallF=1: capture IRdataF into InstrBuf and go to HELD. PCF is held.
  - In FETCH with IReadyF=0: PCF is held. IMissStallF = (state==FETCH) & ~IReadyF. It must not depend on StallF, so no combinational loop forms.
  - In HELD with StallF=1: stay in HELD.
- IF/ID register, in priority order:
  1. FlushD: InstrD=0, ValidD=0, PCPlus8D=0.
  2. StallD: hold.
  3. Delivery: InstrD = IRdataF (FETCH) or InstrBuf (HELD); PCPlus8D = PCF+8; ValidD=1.
  4. Otherwise: bubble (InstrD=0, ValidD=0).
- Arithmetic: PC+4 and PC+8 wrap modulo 2^WIDTH.
- Simultaneous events:
  - Redirect together with delivery: the redirect wins and the delivered instruction is not written to D.
  - FlushD together with StallD: the flush wins.

## Timing
- Reset (asynchronous, immediate):
  - PCF=RESET_PC, state FETCH.
  - InstrD=0, PCPlus8D=0, ValidD=0, InstrBuf=0.
  - Outputs: IReqF=1, IAddrF=RESET_PC.
- Fetch latency: an instruction returned in cycle n (IReadyF=1) appears on InstrD at n+1. Throughput is one instruction per cycle when IReadyF is held at 1.
- A redirect in cycle n gives IAddrF = target in n+1.
- From HELD, StallF falling in cycle n gives the buffered instruction on InstrD in n+1, with IAddrF = old PC+4 in n+1.
- IReqF, IAddrF and IMissStallF are decoded from registered state and PCF, except for the IReadyF term in IMissStallF.
- PCWrPendingF is purely combinational.
- Reset asserted mid-operation abandons any in-flight fetch and discards the buffer.

## Test plan
- Streaming: release reset with RESET_PC=0, IReadyF=1, IRdataF=0xA0+addr.
  - InstrD = 0xA0, 0xA4, 0xA8 on consecutive cycles.
  - PCPlus8D = 8, 12, 16; ValidD=1.
- Miss: IReadyF=0 for 2 cycles at PCF=0x10.
  - IMissStallF=1 for those 2 cycles and ValidD=0 (bubbles).
  - PCF stays 0x10; on IReadyF=1, InstrD = data@0x10 next cycle.
- Hold: StallF=StallD=1 while IReadyF=1 at PCF=0x20.
  - State goes to HELD, IReqF=0, InstrD unchanged.
  - After release, InstrD = data@0x20 one cycle later; IAddrF=0x24.
- Redirect in HELD: BranchTakenE=1, ALUResultE=0x100, FlushD=1.
  - Next cycle: IAddrF=0x100, ValidD=0, buffer dropped.
  - data@0x100 reaches InstrD one cycle after IReadyF.
- Priority: PCSrcW=1 with ResultW=0x200 and BranchTakenE=1 with ALUResultE=0x300 in the same cycle.
  - PCF=0x300.
  - Separately, PCSrcE=1 gives PCWrPendingF=1 in the same cycle.
- Async reset: assert reset low mid-HELD between clock edges.
  - Immediately: ValidD=0, InstrD=0, IAddrF=RESET_PC, IReqF=1.
  - Wrap check: PCF=0xFFFFFFFC delivers with PCPlus8D=0x4, and the next IAddrF=0x0.
